// File: rtl/time_set_ctrl.sv
// ---------------------------------------------------------------------------
// time_set_ctrl
//   Mode/adjust controller for the HH:MM:SS clock datapath. Two raw push
//   buttons are synchronised and debounced. Mode presses step the controller
//   RUN -> SET_HOUR -> SET_MIN -> RUN. Inc presses in a SET state produce
//   single-cycle adjust pulses. Seconds counting is gated while setting, and
//   the digits being set blink at half the 1 Hz tick rate. A SET state with no
//   press activity for TIMEOUT_S ticks returns to RUN on its own.
//
//   Optional feature: define AUTO_REPEAT_EN to make a held inc button issue
//   an extra adjust pulse every REPEAT_CYCLES clocks after the press.
//
// Parameters
//   DEBOUNCE_CYCLES  stable clocks needed before a button level is accepted
//   TIMEOUT_S        idle enable1hz ticks before a SET state falls back to RUN
//   REPEAT_CYCLES    auto-repeat period (used only with AUTO_REPEAT_EN)
//
// Ports
//   clock      in   system clock
//   reset      in   asynchronous active-high reset
//   enable1hz  in   one-cycle tick per second
//   btn_mode   in   raw mode button, active-high, asynchronous
//   btn_inc    in   raw increment button, active-high, asynchronous
//   mode       out  00 RUN, 01 SET_HOUR, 10 SET_MIN (also the FSM state)
//   run_en     out  1 while in RUN: seconds counter may advance
//   inc_min    out  one-cycle minute adjust pulse
//   inc_hour   out  one-cycle hour adjust pulse
//   clr_sec    out  one-cycle pulse clearing seconds on SET_MIN -> RUN
//   blank_h    out  blank hour digits (blink phase in SET_HOUR)
//   blank_m    out  blank minute digits (blink phase in SET_MIN)
// ---------------------------------------------------------------------------
module time_set_ctrl #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int TIMEOUT_S       = 30,
   parameter int REPEAT_CYCLES   = 12_500_000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       enable1hz,
   input  logic       btn_mode,
   input  logic       btn_inc,
   output logic [1:0] mode,
   output logic       run_en,
   output logic       inc_min,
   output logic       inc_hour,
   output logic       clr_sec,
   output logic       blank_h,
   output logic       blank_m
);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int TO_W = $clog2(TIMEOUT_S + 1);

   typedef enum logic [1:0] {
      RUN      = 2'b00,
      SET_HOUR = 2'b01,
      SET_MIN  = 2'b10
   } state_t;

   state_t state, state_nxt;

   // Bit 0 = mode button, bit 1 = inc button.
   logic [1:0]      sync1, sync2, deb, deb_q;
   logic [DB_W-1:0] db_cnt [2];
   logic            mode_ev, inc_ev, rep_ev, any_press;
   logic            in_set, inc_req, timeout_hit, state_chg;
   logic [TO_W-1:0] to_cnt;
   logic            blink_phase;

   // ---------------- synchroniser + debouncer ----------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
         deb   <= '0;
         deb_q <= '0;
         for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
      end else begin
         sync1 <= {btn_inc, btn_mode};
         sync2 <= sync1;
         deb_q <= deb;
         for (int i = 0; i < 2; i++) begin
            // Count consecutive cycles in which the synchronised level
            // disagrees with the accepted one; any agreement restarts it.
            if (sync2[i] != deb[i]) begin
               if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                  deb[i]    <= sync2[i];
                  db_cnt[i] <= '0;
               end else begin
                  db_cnt[i] <= db_cnt[i] + 1'b1;
               end
            end else begin
               db_cnt[i] <= '0;
            end
         end
      end
   end

   assign mode_ev   = deb[0] & ~deb_q[0];
   assign inc_ev    = deb[1] & ~deb_q[1];
   assign in_set    = (state != RUN);
   assign any_press = mode_ev | inc_ev | rep_ev;
   // Mode press wins over a simultaneous inc press or repeat.
   assign inc_req   = in_set & (inc_ev | rep_ev) & ~mode_ev;
   // A press in the same cycle as the final tick keeps the SET state.
   assign timeout_hit = in_set & enable1hz & ~any_press &
                        (to_cnt == TO_W'(TIMEOUT_S - 1));
   assign state_chg = (state_nxt != state);

   // ---------------- optional auto-repeat ----------------
`ifdef AUTO_REPEAT_EN
   localparam int RP_W = $clog2(REPEAT_CYCLES + 1);
   logic            rep_act;
   logic [RP_W-1:0] rep_cnt;

   // Armed only by an accepted press in the current SET state, so a button
   // already held when a SET state is entered does not repeat.
   assign rep_ev = rep_act & deb[1] & (rep_cnt == RP_W'(REPEAT_CYCLES - 1));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rep_act <= 1'b0;
         rep_cnt <= '0;
      end else if (state_chg || !deb[1]) begin
         rep_act <= 1'b0;
         rep_cnt <= '0;
      end else if (inc_req) begin
         rep_act <= 1'b1;
         rep_cnt <= '0;
      end else if (rep_act) begin
         rep_cnt <= rep_cnt + 1'b1;
      end
   end
`else
   // Repeat disabled; the parameter is referenced only so both builds share
   // one interface.
   assign rep_ev = 1'b0 && (REPEAT_CYCLES > 0);
`endif

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= RUN;
      else       state <= state_nxt;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         RUN:      if (mode_ev) state_nxt = SET_HOUR;
         SET_HOUR: if (mode_ev) state_nxt = SET_MIN;
                   else if (timeout_hit) state_nxt = RUN;
         SET_MIN:  if (mode_ev || timeout_hit) state_nxt = RUN;
         default:  state_nxt = RUN;
      endcase
   end

   // ---------------- FSM: output decode ----------------
   always_comb begin
      mode    = state;
      run_en  = (state == RUN);
      blank_h = (state == SET_HOUR) & blink_phase;
      blank_m = (state == SET_MIN)  & blink_phase;
   end

   // ---------------- registered pulses ----------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         inc_hour <= 1'b0;
         inc_min  <= 1'b0;
         clr_sec  <= 1'b0;
      end else begin
         inc_hour <= inc_req & (state == SET_HOUR);
         inc_min  <= inc_req & (state == SET_MIN);
         // Only a mode press leaving SET_MIN clears seconds, not a timeout.
         clr_sec  <= (state == SET_MIN) & mode_ev;
      end
   end

   // ---------------- timeout counter and blink phase ----------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         to_cnt      <= '0;
         blink_phase <= 1'b0;
      end else begin
         if (state_chg || any_press || !in_set) to_cnt <= '0;
         else if (enable1hz)                    to_cnt <= to_cnt + 1'b1;

         if (state_chg)                  blink_phase <= 1'b0;
         else if (in_set && enable1hz)   blink_phase <= ~blink_phase;
      end
   end

endmodule
